// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_INC          = 4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0080;

    // Next-PC source after priority resolution; a stall is handled as a hold on top of this.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_EXC
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a saturating count.
// A push on a full stack overwrites the oldest entry; push+pop together replaces the top.
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;   // index of the most recent entry
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(RAS_DEPTH));
    assign top   = empty ? '0 : mem_q[ptr_q];

    // Pointer/count next state and write slot selection
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push) begin
            // Empty push+pop lands here as well: it simply pushes one entry.
            ptr_d  = ptr_q + PW'(1);
            wr_en  = 1'b1;
            wr_idx = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; no reset needed since top is masked while the count is zero
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC mux, PC register, target alignment check
// and return-address prediction check against a small RAS.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     INC          = PC_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             exc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_mispredict,
    output logic             misalign
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic             mispredict_q, mispredict_d;
    logic [WIDTH-1:0] target;
    logic             hold;
    logic             push_en, pop_en;
    pc_sel_e          sel;

    assign pc_plus = pc_q + WIDTH'(INC);

    // An exception beats a stall; otherwise a stall freezes the PC and the RAS.
    assign hold    = stall & ~exc;
    assign push_en = ras_push & ~stall;
    assign pop_en  = ras_pop & ~stall;

    // Resolve the next-PC source by priority
    always_comb begin
        sel = SEL_SEQ;
        if (exc) begin
            sel = SEL_EXC;
        end else if (jr) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    // Next PC, with redirect targets forced to word alignment
    always_comb begin
        target     = pc_plus;
        pc_d       = pc_plus;
        misalign_d = 1'b0;
        unique case (sel)
            SEL_JR:  target = jr_target;
            SEL_J:   target = jump_target;
            SEL_BR:  target = branch_target;
            default: target = pc_plus;
        endcase
        if (hold) begin
            pc_d = pc_q;
        end else if (sel == SEL_EXC) begin
            pc_d = EXC_VECTOR;
        end else if (sel != SEL_SEQ) begin
            pc_d       = {target[WIDTH-1:2], 2'b00};
            misalign_d = |target[1:0];
        end
    end

    // Compare the predicted return address before the stack is updated
    always_comb begin
        mispredict_d = pop_en & (ras_empty | (ras_top != jr_target));
    end

    // PC and pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            misalign_q   <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misalign_q   <= misalign_d;
            mispredict_q <= mispredict_d;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_en),
        .pop   (pop_en),
        .din   (pc_plus),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign pc             = pc_q;
    assign misalign       = misalign_q;
    assign ras_mispredict = mispredict_q;

endmodule
